// File: rtl/icb_ext_arbiter.sv
// Round-robin N-to-1 arbiter sharing one icb_ext slave port; one transaction in flight,
// grant held from command acceptance through the final write and response beats.
module icb_ext_arbiter #(
    parameter int unsigned NUM_M  = 2,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LEN_W  = 3,
    localparam int unsigned MASK_W = WIDTH / 8,
    localparam int unsigned GW     = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          m_cmd_valid,
    output logic [NUM_M-1:0]          m_cmd_ready,
    input  logic [NUM_M*ADDR_W-1:0]   m_cmd_addr,
    input  logic [NUM_M-1:0]          m_cmd_read,
    input  logic [NUM_M*LEN_W-1:0]    m_cmd_len,
    input  logic [NUM_M-1:0]          m_wr_valid,
    output logic [NUM_M-1:0]          m_wr_ready,
    input  logic [NUM_M*WIDTH-1:0]    m_wr_data,
    input  logic [NUM_M*MASK_W-1:0]   m_wr_mask,
    output logic [NUM_M-1:0]          m_rsp_valid,
    input  logic [NUM_M-1:0]          m_rsp_ready,
    output logic [WIDTH-1:0]          m_rsp_data,
    output logic                      m_rsp_err,
    output logic                      s_cmd_valid,
    input  logic                      s_cmd_ready,
    output logic [ADDR_W-1:0]         s_cmd_addr,
    output logic                      s_cmd_read,
    output logic [LEN_W-1:0]          s_cmd_len,
    output logic                      s_wr_valid,
    input  logic                      s_wr_ready,
    output logic [WIDTH-1:0]          s_wr_data,
    output logic [MASK_W-1:0]         s_wr_mask,
    input  logic                      s_rsp_valid,
    output logic                      s_rsp_ready,
    input  logic [WIDTH-1:0]          s_rsp_data,
    input  logic                      s_rsp_err,
    output logic [GW-1:0]             grant_idx,
    output logic                      busy
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RSP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_rr_ptr;
    logic [LEN_W-1:0]      r_wr_cnt;
    logic [LEN_W-1:0]      r_rsp_cnt;

    logic                  w_any;
    logic [2*NUM_M-1:0]    w_dbl;
    logic [NUM_M-1:0]      w_rot;
    logic [GW-1:0]         w_off;
    logic [GW:0]           w_sum;
    logic [GW-1:0]         w_winner;

    logic [NUM_M-1:0]      w_onehot;
    logic                  w_cmd_valid_g;
    logic [ADDR_W-1:0]     w_cmd_addr_g;
    logic                  w_cmd_read_g;
    logic [LEN_W-1:0]      w_cmd_len_g;
    logic                  w_wr_valid_g;
    logic [WIDTH-1:0]      w_wr_data_g;
    logic [MASK_W-1:0]     w_wr_mask_g;
    logic                  w_rsp_ready_g;

    logic                  w_cmd_hs;
    logic                  w_wr_hs;
    logic                  w_rsp_hs;

    // Rotate requests so bit k is master (rr_ptr+k) mod NUM_M; lowest set bit wins.
    always_comb begin
        w_any    = |m_cmd_valid;
        w_dbl    = {m_cmd_valid, m_cmd_valid} >> r_rr_ptr;
        w_rot    = w_dbl[NUM_M-1:0];
        w_off    = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = GW'(k);
        end
        w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_winner = (w_sum >= (GW+1)'(NUM_M)) ? GW'(w_sum - (GW+1)'(NUM_M)) : GW'(w_sum);
    end

    always_comb begin
        w_onehot      = '0;
        w_cmd_valid_g = 1'b0;
        w_cmd_addr_g  = '0;
        w_cmd_read_g  = 1'b0;
        w_cmd_len_g   = '0;
        w_wr_valid_g  = 1'b0;
        w_wr_data_g   = '0;
        w_wr_mask_g   = '0;
        w_rsp_ready_g = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (GW'(i) == r_grant) begin
                w_onehot[i]   = 1'b1;
                w_cmd_valid_g = m_cmd_valid[i];
                w_cmd_addr_g  = m_cmd_addr[i*ADDR_W +: ADDR_W];
                w_cmd_read_g  = m_cmd_read[i];
                w_cmd_len_g   = m_cmd_len[i*LEN_W +: LEN_W];
                w_wr_valid_g  = m_wr_valid[i];
                w_wr_data_g   = m_wr_data[i*WIDTH +: WIDTH];
                w_wr_mask_g   = m_wr_mask[i*MASK_W +: MASK_W];
                w_rsp_ready_g = m_rsp_ready[i];
            end
        end
    end

    assign w_cmd_hs = s_cmd_valid & s_cmd_ready;
    assign w_wr_hs  = s_wr_valid & s_wr_ready;
    assign w_rsp_hs = s_rsp_valid & s_rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_CMD;
            S_CMD:   if (w_cmd_hs) w_state_nxt = w_cmd_read_g ? S_RSP : S_WDATA;
            S_WDATA: if (w_wr_hs && (r_wr_cnt == '0)) w_state_nxt = S_RSP;
            S_RSP:   if (w_rsp_hs && (r_rsp_cnt == '0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant, round-robin pointer and remaining-beat counters (count down to 0, never wrap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_wr_cnt  <= '0;
            r_rsp_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) r_grant <= w_winner;
                S_CMD: begin
                    if (w_cmd_hs) begin
                        if (w_cmd_read_g) r_rsp_cnt <= w_cmd_len_g;
                        else              r_wr_cnt  <= w_cmd_len_g;
                    end
                end
                S_WDATA: begin
                    if (w_wr_hs) begin
                        if (r_wr_cnt == '0) r_rsp_cnt <= '0;
                        else                r_wr_cnt  <= r_wr_cnt - LEN_W'(1);
                    end
                end
                S_RSP: begin
                    if (w_rsp_hs) begin
                        if (r_rsp_cnt == '0)
                            r_rr_ptr <= (r_grant == GW'(NUM_M - 1)) ? '0 : r_grant + GW'(1);
                        else
                            r_rsp_cnt <= r_rsp_cnt - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Channel routing: only the phase-owning channel of the granted master is connected.
    always_comb begin
        m_cmd_ready = '0;
        m_wr_ready  = '0;
        m_rsp_valid = '0;
        m_rsp_data  = '0;
        m_rsp_err   = 1'b0;
        s_cmd_valid = 1'b0;
        s_cmd_addr  = '0;
        s_cmd_read  = 1'b0;
        s_cmd_len   = '0;
        s_wr_valid  = 1'b0;
        s_wr_data   = '0;
        s_wr_mask   = '0;
        s_rsp_ready = 1'b0;
        grant_idx   = r_grant;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_CMD: begin
                s_cmd_valid = w_cmd_valid_g;
                s_cmd_addr  = w_cmd_addr_g;
                s_cmd_read  = w_cmd_read_g;
                s_cmd_len   = w_cmd_len_g;
                m_cmd_ready = w_onehot & {NUM_M{s_cmd_ready}};
            end
            S_WDATA: begin
                s_wr_valid = w_wr_valid_g;
                s_wr_data  = w_wr_data_g;
                s_wr_mask  = w_wr_mask_g;
                m_wr_ready = w_onehot & {NUM_M{s_wr_ready}};
            end
            S_RSP: begin
                m_rsp_valid = w_onehot & {NUM_M{s_rsp_valid}};
                s_rsp_ready = w_rsp_ready_g;
                m_rsp_data  = s_rsp_data;
                m_rsp_err   = s_rsp_err;
            end
            default: ;
        endcase
    end

endmodule
